// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: FSM state codes and the
// channel-select width helper.
package alarm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RINGING = 2'b01;
  localparam logic [1:0] ST_SNOOZE  = 2'b10;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alarm_match.sv
// One alarm channel: stored alarm time, equality comparator and the
// match-edge detector that produces a single trigger per entry into a match.
module alarm_match #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] current_time,
  input  logic [WIDTH-1:0] alarm_in,
  output logic [WIDTH-1:0] value,
  output logic             trig
);

  logic match;
  logic match_prev;

  assign match = (value == current_time);
  assign trig  = tick & match & ~match_prev & en;

  // match_prev resets high so a channel sitting at the reset time stays quiet
  always_ff @(posedge clock) begin
    if (reset) begin
      value      <= '0;
      match_prev <= 1'b1;
    end else begin
      if (load) value <= alarm_in;
      if (tick) match_prev <= match;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Multi-channel alarm controller: per-channel match detection, lowest-index
// priority select, ring/snooze/auto-timeout FSM and the display mux.
module alarm_ctrl import alarm_pkg::*; #(
  parameter  int WIDTH        = 4,
  parameter  int N_ALARMS     = 2,
  parameter  int SNOOZE_TICKS = 5,
  parameter  int RING_TICKS   = 10,
  localparam int SEL_W        = sel_w(N_ALARMS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [WIDTH-1:0]    current_time,
  input  logic                load_alarm,
  input  logic [SEL_W-1:0]    load_sel,
  input  logic [WIDTH-1:0]    alarm_in,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                show_a,
  input  logic [SEL_W-1:0]    show_sel,
  input  logic                snooze,
  input  logic                alarm_off,
  output logic [WIDTH-1:0]    display_time,
  output logic                sound_alarm,
  output logic [SEL_W-1:0]    active_alarm,
  output logic                ringing,
  output logic                snoozing
);

  localparam int MAX_T = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  logic [WIDTH-1:0]    alarm_val [N_ALARMS];
  logic [N_ALARMS-1:0] trig;
  logic [SEL_W-1:0]    fire_idx;
  logic [1:0]          state, state_next;
  logic [CNT_W-1:0]    tcnt, tcnt_next, tcnt_inc;
  logic [SEL_W-1:0]    active_next;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_ch
    alarm_match #(.WIDTH(WIDTH)) u_match (
      .clock        (clock),
      .reset        (reset),
      .tick         (tick),
      .load         (load_alarm && (load_sel == SEL_W'(i))),
      .en           (alarm_en[i]),
      .current_time (current_time),
      .alarm_in     (alarm_in),
      .value        (alarm_val[i]),
      .trig         (trig[i])
    );
  end

  always_comb begin
    fire_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (trig[i]) fire_idx = SEL_W'(i);
  end

  always_comb begin
    display_time = current_time;
    if (show_a) begin
      display_time = '0;
      for (int i = 0; i < N_ALARMS; i++)
        if (show_sel == SEL_W'(i)) display_time = alarm_val[i];
    end
  end

  assign tcnt_inc = tcnt + 1'b1;

  // Request priority inside an active alarm: off, enable-clear, snooze, tick
  always_comb begin
    state_next  = state;
    tcnt_next   = tcnt;
    active_next = active_alarm;
    case (state)
      ST_IDLE: begin
        if (|trig) begin
          state_next  = ST_RINGING;
          tcnt_next   = '0;
          active_next = fire_idx;
        end
      end
      ST_RINGING: begin
        if (alarm_off || !alarm_en[active_alarm]) begin
          state_next = ST_IDLE;
        end else if (snooze) begin
          state_next = ST_SNOOZE;
          tcnt_next  = '0;
        end else if (tick) begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == CNT_W'(RING_TICKS)) begin
            state_next = ST_IDLE;
            tcnt_next  = '0;
          end
        end
      end
      ST_SNOOZE: begin
        if (alarm_off || !alarm_en[active_alarm]) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == CNT_W'(SNOOZE_TICKS)) begin
            state_next = ST_RINGING;
            tcnt_next  = '0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they never glitch on decode
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      tcnt         <= '0;
      active_alarm <= '0;
      sound_alarm  <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      state        <= state_next;
      tcnt         <= tcnt_next;
      active_alarm <= active_next;
      sound_alarm  <= (state_next == ST_RINGING);
      ringing      <= (state_next == ST_RINGING);
      snoozing     <= (state_next == ST_SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus a randomized phase, every
// cycle compared against a countdown-based behavioural model.
module tb_alarm_ctrl;

  logic       clock = 1'b0;
  logic       reset, tick, load_alarm, load_sel, show_a, show_sel, snooze, alarm_off;
  logic [3:0] current_time, alarm_in;
  logic [1:0] alarm_en;
  logic [3:0] display_time;
  logic       sound_alarm, active_alarm, ringing, snoozing;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 = idle, 1 = ringing, 2 = snoozed; m_left = ticks remaining
  int m_alarm [2];
  bit m_prev  [2];
  int m_mode, m_left, m_active;

  alarm_ctrl #(.WIDTH(4), .N_ALARMS(2), .SNOOZE_TICKS(3), .RING_TICKS(4)) dut (
    .clock(clock), .reset(reset), .tick(tick), .current_time(current_time),
    .load_alarm(load_alarm), .load_sel(load_sel), .alarm_in(alarm_in),
    .alarm_en(alarm_en), .show_a(show_a), .show_sel(show_sel), .snooze(snooze),
    .alarm_off(alarm_off), .display_time(display_time), .sound_alarm(sound_alarm),
    .active_alarm(active_alarm), .ringing(ringing), .snoozing(snoozing)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_alarm = '{0, 0};
    m_prev  = '{1, 1};
    m_mode = 0; m_left = 0; m_active = 0;
  endtask

  task automatic model_edge();
    bit mt [2];
    bit tr [2];
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      mt[i] = (m_alarm[i] == int'(current_time));
      tr[i] = tick && mt[i] && !m_prev[i] && alarm_en[i];
    end
    if (m_mode == 0) begin
      if (tr[0] || tr[1]) begin
        m_mode = 1; m_left = 4; m_active = tr[0] ? 0 : 1;
      end
    end else if (alarm_off || !alarm_en[m_active]) begin
      m_mode = 0;
    end else if (m_mode == 1 && snooze) begin
      m_mode = 2; m_left = 3;
    end else if (tick) begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 1) m_mode = 0;
        else begin m_mode = 1; m_left = 4; end
      end
    end
    if (tick) m_prev = mt;
    if (load_alarm) m_alarm[load_sel] = int'(alarm_in);
  endtask

  // One clock: check display with the driven inputs, advance model at the
  // edge, check registered outputs on the following falling edge.
  task automatic step();
    #1;
    check("display_time", display_time, show_a ? m_alarm[show_sel] : int'(current_time));
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("sound_alarm", sound_alarm, m_mode == 1);
    check("ringing", ringing, m_mode == 1);
    check("snoozing", snoozing, m_mode == 2);
    check("active_alarm", active_alarm, m_active);
    reset = 0; tick = 0; load_alarm = 0; snooze = 0; alarm_off = 0;
  endtask

  task automatic tick_at(input int t);
    current_time = 4'(t); tick = 1; step();
  endtask

  task automatic load(input int ch, input int v);
    load_alarm = 1; load_sel = ch[0]; alarm_in = 4'(v); step();
  endtask

  initial begin
    reset = 1; tick = 0; current_time = 0; load_alarm = 0; load_sel = 0;
    alarm_in = 0; alarm_en = 2'b00; show_a = 0; show_sel = 0; snooze = 0; alarm_off = 0;
    model_reset();
    @(negedge clock);
    reset = 1; step();
    check("reset_sound", sound_alarm, 0);
    check("reset_active", active_alarm, 0);

    // Basic fire on entry into a match, no retrigger while it persists
    load(0, 1); alarm_en = 2'b01;
    tick_at(2); tick_at(1);
    check("basic_fire", sound_alarm, 1);
    tick_at(1);
    alarm_off = 1; step();
    tick_at(1);
    check("no_retrigger", sound_alarm, 0);

    // Snooze then re-ring after three ticks
    tick_at(2); tick_at(1);
    snooze = 1; step();
    check("snooze_silent", sound_alarm, 0);
    check("snooze_flag", snoozing, 1);
    tick_at(1); tick_at(1);
    check("snooze_wait", sound_alarm, 0);
    tick_at(1);
    check("snooze_rering", sound_alarm, 1);

    // Auto-off after four ticks, then channel 1 still fires
    tick_at(1); tick_at(1); tick_at(1);
    check("ring_hold", sound_alarm, 1);
    tick_at(1);
    check("auto_off", sound_alarm, 0);
    load(1, 6); alarm_en = 2'b11;
    tick_at(6);
    check("ch1_active", active_alarm, 1);
    alarm_off = 1; step();

    // Both channels match together: lowest index wins; off beats snooze
    load(0, 5); load(1, 5);
    tick_at(4); tick_at(5);
    check("prio_active", active_alarm, 0);
    snooze = 1; alarm_off = 1; step();
    check("off_over_snooze", snoozing, 0);

    // Display mux and load-with-trigger uses the old value
    load(1, 9); show_a = 1; show_sel = 1; step();
    show_a = 0; current_time = 4'd12; step();
    load(0, 3); tick_at(6);
    current_time = 4'd7; tick = 1; load_alarm = 1; load_sel = 0; alarm_in = 4'd7; step();
    check("load_same_cycle", sound_alarm, 0);
    tick_at(8); tick_at(7);
    check("new_value_fires", sound_alarm, 1);

    // Reset while ringing, then enable clear while snoozed
    reset = 1; show_a = 1; show_sel = 0; step();
    check("reset_ring", sound_alarm, 0);
    check("reset_alarm_val", display_time, 0);
    show_a = 0;
    load(1, 2); alarm_en = 2'b10;
    tick_at(1); tick_at(2);
    snooze = 1; step();
    alarm_en = 2'b00; step();
    check("en_clear", snoozing, 0);

    // Randomized phase
    alarm_en = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) reset = 1;
      if ($urandom_range(0, 1) == 0) begin
        tick = 1; current_time = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) begin
        load_alarm = 1; load_sel = 1'($urandom_range(0, 1));
        alarm_in = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) snooze = 1;
      if ($urandom_range(0, 31) == 0) alarm_off = 1;
      if ($urandom_range(0, 31) == 0) alarm_en = 2'($urandom_range(0, 3));
      show_a = 1'($urandom_range(0, 1));
      show_sel = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
